// File: rtl/hpm_counter_bank.sv
// Machine-mode counter bank: cycle, instret and NUM_COUNTERS event counters with
// per-counter inhibit, sticky wrap flags and a shadowed lo/hi read path for RV32.
module hpm_counter_bank #(
    parameter  int COUNTER_W    = 33,
    parameter  int NUM_COUNTERS = 4,
    parameter  int NUM_EVENTS   = 8,
    parameter  int COMMIT_PORTS = 2,
    localparam int TOTAL        = NUM_COUNTERS + 2,
    localparam int IDX_W        = $clog2(TOTAL),
    localparam int EV_W         = $clog2(NUM_EVENTS + 1),
    localparam int RET_W        = $clog2(COMMIT_PORTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [RET_W-1:0]      retire_cnt,
    input  logic                  wr_en,
    input  logic [1:0]            wr_type,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic                  rd_hi,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic [TOTAL-1:0]      overflow,
    input  logic [TOTAL-1:0]      overflow_clr
);

    localparam int              HI_W    = COUNTER_W - 32;
    localparam logic [IDX_W:0]  TOTAL_X = (IDX_W + 1)'(TOTAL);
    localparam logic [RET_W-1:0] MAX_RET = RET_W'(COMMIT_PORTS);

    logic [COUNTER_W-1:0] cnt_q   [TOTAL];
    logic [COUNTER_W-1:0] cnt_d   [TOTAL];
    logic [EV_W-1:0]      evsel_q [TOTAL];
    logic [EV_W-1:0]      evsel_d [TOTAL];
    logic [COUNTER_W:0]   inc     [TOTAL];
    logic [COUNTER_W:0]   sum     [TOTAL];
    logic [TOTAL-1:0]     cnt_wr;
    logic [TOTAL-1:0]     inhibit_q, inhibit_d;
    logic [TOTAL-1:0]     ovf_q, ovf_d;
    logic [HI_W-1:0]      shadow_q, shadow_d;
    logic [IDX_W-1:0]     tag_q, tag_d;
    logic                 shadow_vld_q, shadow_vld_d;
    logic [31:0]          rd_data_q, rd_data_d;
    logic                 rd_valid_q;
    logic                 wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_idx} < TOTAL_X);

    // Per-counter increment amount; the extra top bit of sum is the wrap carry.
    always_comb begin
        for (int k = 0; k < TOTAL; k++) begin
            inc[k] = '0;
            if (k == 0) begin
                inc[k] = (COUNTER_W + 1)'(1);
            end else if (k == 1) begin
                inc[k] = (COUNTER_W + 1)'(retire_cnt);
            end else begin
                for (int e = 1; e <= NUM_EVENTS; e++) begin
                    if (evsel_q[k] == EV_W'(e) && event_i[e-1]) begin
                        inc[k] = (COUNTER_W + 1)'(1);
                    end
                end
            end
            sum[k]    = {1'b0, cnt_q[k]} + inc[k];
            cnt_wr[k] = wr_ok && (wr_idx == IDX_W'(k)) && !wr_type[1];
        end
    end

    // A lo/hi write replaces the increment for that counter and never flags a wrap.
    always_comb begin
        ovf_d = ovf_q & ~overflow_clr;
        for (int k = 0; k < TOTAL; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_wr[k]) begin
                if (wr_type[0]) begin
                    cnt_d[k][COUNTER_W-1:32] = wr_data[HI_W-1:0];
                end else begin
                    cnt_d[k][31:0] = wr_data;
                end
            end else if (!inhibit_q[k]) begin
                cnt_d[k] = sum[k][COUNTER_W-1:0];
                if (sum[k][COUNTER_W]) begin
                    ovf_d[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        inhibit_d = inhibit_q;
        evsel_d   = evsel_q;
        if (wr_en && wr_type == 2'd3) begin
            inhibit_d = wr_data[TOTAL-1:0];
        end
        for (int k = 2; k < TOTAL; k++) begin
            if (wr_ok && wr_type == 2'd2 && wr_idx == IDX_W'(k)) begin
                evsel_d[k] = wr_data[EV_W-1:0];
            end
        end
    end

    // Reads see pre-write, pre-increment state; a lo read snapshots the upper half.
    always_comb begin
        rd_data_d    = rd_data_q;
        shadow_d     = shadow_q;
        tag_d        = tag_q;
        shadow_vld_d = shadow_vld_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int k = 0; k < TOTAL; k++) begin
                if (rd_idx == IDX_W'(k)) begin
                    if (!rd_hi) begin
                        rd_data_d    = cnt_q[k][31:0];
                        shadow_d     = cnt_q[k][COUNTER_W-1:32];
                        tag_d        = rd_idx;
                        shadow_vld_d = 1'b1;
                    end else if (shadow_vld_q && tag_q == rd_idx) begin
                        rd_data_d = 32'(shadow_q);
                    end else begin
                        rd_data_d = 32'(cnt_q[k][COUNTER_W-1:32]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TOTAL; k++) begin
                cnt_q[k]   <= '0;
                evsel_q[k] <= '0;
            end
            inhibit_q    <= '0;
            ovf_q        <= '0;
            shadow_q     <= '0;
            tag_q        <= '0;
            shadow_vld_q <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            for (int k = 0; k < TOTAL; k++) begin
                cnt_q[k]   <= cnt_d[k];
                evsel_q[k] <= evsel_d[k];
            end
            inhibit_q    <= inhibit_d;
            ovf_q        <= ovf_d;
            shadow_q     <= shadow_d;
            tag_q        <= tag_d;
            shadow_vld_q <= shadow_vld_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_en;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = ovf_q;

    retire_legal: assert property (@(posedge clk) disable iff (!rst_n) retire_cnt <= MAX_RET);

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboard bench for hpm_counter_bank: a behavioural model predicts read data and
// overflow flags; a monitor pops and compares them as the DUT presents results.
module tb_hpm_counter_bank;

    localparam int CW    = 33;
    localparam int NC    = 4;
    localparam int NE    = 8;
    localparam int CP    = 2;
    localparam int TOTAL = NC + 2;
    localparam longint unsigned MOD     = 64'h1 << CW;
    localparam longint unsigned HI_MASK = (64'h1 << (CW - 32)) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  event_i;
    logic [1:0]  retire_cnt;
    logic        wr_en;
    logic [1:0]  wr_type;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_idx;
    logic        rd_hi;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [5:0]  overflow;
    logic [5:0]  overflow_clr;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] readQ[$];
    logic [5:0]  ovfQ[$];

    longint unsigned mCnt[TOTAL];
    int              mEvsel[TOTAL];
    logic [5:0]      mInh;
    logic [5:0]      mOvf;
    longint unsigned mShadow;
    int              mTag;
    bit              mShVld;

    always #5 clk = ~clk;

    hpm_counter_bank #(
        .COUNTER_W(CW), .NUM_COUNTERS(NC), .NUM_EVENTS(NE), .COMMIT_PORTS(CP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .event_i(event_i), .retire_cnt(retire_cnt),
        .wr_en(wr_en), .wr_type(wr_type), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_hi(rd_hi), .rd_data(rd_data),
        .rd_valid(rd_valid), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic modelReset();
        for (int k = 0; k < TOTAL; k++) begin
            mCnt[k]   = 0;
            mEvsel[k] = 0;
        end
        mInh    = '0;
        mOvf    = '0;
        mShadow = 0;
        mTag    = 0;
        mShVld  = 0;
        readQ.delete();
        ovfQ.delete();
    endtask

    // One clock edge of the architectural behaviour, using plain 64-bit arithmetic.
    task automatic modelStep(input logic wen, input logic [1:0] wt, input logic [2:0] wi,
                             input logic [31:0] wd, input logic ren, input logic [2:0] ri,
                             input logic rh, input logic [7:0] ev, input logic [1:0] ret,
                             input logic [5:0] clr);
        logic [31:0]     exp;
        logic [5:0]      setv;
        longint unsigned step;
        longint unsigned nv;
        int              e;
        setv = '0;
        if (ren) begin
            if (int'(ri) >= TOTAL) exp = 32'h0;
            else if (!rh) begin
                exp     = 32'(mCnt[ri]);
                mShadow = mCnt[ri] >> 32;
                mTag    = int'(ri);
                mShVld  = 1;
            end else if (mShVld && mTag == int'(ri)) exp = 32'(mShadow);
            else exp = 32'(mCnt[ri] >> 32);
            readQ.push_back(exp);
        end
        for (int k = 0; k < TOTAL; k++) begin
            if (wen && int'(wi) == k && wt <= 2'd1) begin
                if (wt == 2'd0) mCnt[k] = (mCnt[k] & ~64'hFFFF_FFFF) | {32'h0, wd};
                else mCnt[k] = (mCnt[k] & 64'hFFFF_FFFF) | (({32'h0, wd} & HI_MASK) << 32);
            end else if (!mInh[k]) begin
                if (k == 0) step = 1;
                else if (k == 1) step = longint'(ret);
                else begin
                    e    = mEvsel[k];
                    step = (e >= 1 && e <= NE && ev[e-1]) ? 1 : 0;
                end
                nv = mCnt[k] + step;
                if (nv >= MOD) begin
                    nv      = nv - MOD;
                    setv[k] = 1'b1;
                end
                mCnt[k] = nv;
            end
        end
        mOvf = (mOvf & ~clr) | setv;
        if (wen && wt == 2'd3) mInh = wd[5:0];
        if (wen && wt == 2'd2 && wi >= 3'd2 && int'(wi) < TOTAL) mEvsel[wi] = int'(wd[3:0]);
        ovfQ.push_back(mOvf);
    endtask

    // Drive one cycle at a falling edge, predict it, then wait for the next falling edge.
    task automatic applyStimulus(input logic wen, input logic [1:0] wt, input logic [2:0] wi,
                                 input logic [31:0] wd, input logic ren, input logic [2:0] ri,
                                 input logic rh, input logic [7:0] ev, input logic [1:0] ret,
                                 input logic [5:0] clr);
        wr_en = wen; wr_type = wt; wr_idx = wi; wr_data = wd;
        rd_en = ren; rd_idx = ri; rd_hi = rh;
        event_i = ev; retire_cnt = ret; overflow_clr = clr;
        modelStep(wen, wt, wi, wd, ren, ri, rh, ev, ret, clr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h0, 2'd0, 6'h0);
    endtask

    task automatic writeReg(input logic [1:0] wt, input logic [2:0] wi, input logic [31:0] wd);
        applyStimulus(1'b1, wt, wi, wd, 1'b0, 3'd0, 1'b0, 8'h0, 2'd0, 6'h0);
    endtask

    task automatic readReg(input logic [2:0] ri, input logic rh);
        applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b1, ri, rh, 8'h0, 2'd0, 6'h0);
    endtask

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (rd_valid) begin
                if (readQ.size() == 0) checkOutput("rd_valid_unexpected", 32'(rd_valid), 32'h0);
                else checkOutput("rd_data", rd_data, readQ.pop_front());
            end
            if (ovfQ.size() > 0) checkOutput("overflow", 32'(overflow), 32'(ovfQ.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        wen, ren, rh;
        logic [1:0]  wt, ret;
        logic [2:0]  wi, ri;
        logic [31:0] wd;
        logic [7:0]  ev;
        logic [5:0]  clr;

        rst_n = 1'b0;
        wr_en = 0; wr_type = 0; wr_idx = 0; wr_data = 0;
        rd_en = 0; rd_idx = 0; rd_hi = 0;
        event_i = 0; retire_cnt = 0; overflow_clr = 0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("reset_rd_data", rd_data, 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);
        rst_n = 1'b1;

        // Idle counting: cycle advances, instret stays at zero.
        idle(10);
        readReg(3'd0, 1'b0);
        readReg(3'd1, 1'b0);
        readReg(3'd1, 1'b1);

        // instret wraps from all-ones by +2; then clear collides with a new wrap.
        writeReg(2'd0, 3'd1, 32'hFFFF_FFFF);
        writeReg(2'd1, 3'd1, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h0, 2'd2, 6'h0);
        readReg(3'd1, 1'b0);
        writeReg(2'd0, 3'd1, 32'hFFFF_FFFF);
        writeReg(2'd1, 3'd1, 32'h1);
        applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h0, 2'd1, 6'b000010);
        applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h0, 2'd0, 6'b000010);

        // hpm counter at index 2 listening to event 3, then inhibited.
        writeReg(2'd2, 3'd2, 32'h3);
        repeat (4) applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h05, 2'd0, 6'h0);
        applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h04, 2'd0, 6'h0);
        readReg(3'd2, 1'b0);
        writeReg(2'd3, 3'd0, 32'h4);
        repeat (3) applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h04, 2'd0, 6'h0);
        readReg(3'd2, 1'b0);
        writeReg(2'd3, 3'd0, 32'h0);

        // Write/increment and write/read collisions on the cycle counter.
        applyStimulus(1'b1, 2'd0, 3'd0, 32'h100, 1'b1, 3'd0, 1'b0, 8'h0, 2'd0, 6'h0);
        readReg(3'd0, 1'b0);

        // Shadowed hi read keeps the snapshot while the live counter wraps.
        writeReg(2'd0, 3'd0, 32'hFFFF_FFFE);
        writeReg(2'd1, 3'd0, 32'h1);
        readReg(3'd0, 1'b0);
        idle(4);
        readReg(3'd0, 1'b1);
        readReg(3'd1, 1'b1);

        // Out-of-range index and an ignored event select on the cycle counter.
        writeReg(2'd0, 3'd6, 32'h1234_5678);
        writeReg(2'd2, 3'd7, 32'h1);
        readReg(3'd6, 1'b0);
        readReg(3'd7, 1'b1);
        writeReg(2'd2, 3'd0, 32'h1);
        repeat (3) applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 8'h00, 2'd0, 6'h0);
        applyStimulus(1'b0, 2'd0, 3'd0, 32'h0, 1'b1, 3'd0, 1'b0, 8'h01, 2'd0, 6'h0);
        readReg(3'd0, 1'b0);

        // Randomized traffic, biased toward near-max presets so wraps occur.
        for (int i = 0; i < 400; i++) begin
            wen = ($urandom_range(0, 3) == 0);
            wt  = 2'($urandom_range(0, 3));
            wi  = 3'($urandom_range(0, 7));
            case (wt)
                2'd0:    wd = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                2'd1:    wd = ($urandom_range(0, 2) != 0) ? 32'h1 : $urandom;
                2'd2:    wd = 32'($urandom_range(0, 15));
                default: wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            endcase
            ren = ($urandom_range(0, 3) != 0);
            ri  = 3'($urandom_range(0, 7));
            rh  = 1'($urandom_range(0, 1));
            ev  = 8'($urandom);
            ret = 2'($urandom_range(0, CP));
            clr = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
            applyStimulus(wen, wt, wi, wd, ren, ri, rh, ev, ret, clr);
        end

        checkOutput("pending_reads", 32'(readQ.size()), 32'h0);

        // Reset asserted while a read result is being presented.
        readReg(3'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midread_reset_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("midread_reset_rd_data", rd_data, 32'h0);
        checkOutput("midread_reset_overflow", 32'(overflow), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
